dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data memory between two requesters: port 0 = CPU
//   load/store path, port 1 = loader/debug DMA. Round-robin arbitration, one
//   access in flight, 3-state FSM (IDLE -> ACCESS -> RESP). Sits between the
//   requesters and the data memory (combinational read, write on posedge).
// PARAMETERS
//   ADDR_W   15   data memory word-address width
//   DATA_W   32   data word width
// PORTS
//   clk        in   1       system clock, all state on posedge
//   rst_n      in   1       asynchronous, active-low reset
//   req0       in   1       port 0 request; hold with we0/addr0/wdata0 until gnt0
//   we0        in   1       port 0: 1 = write, 0 = read
//   addr0      in   ADDR_W  port 0 word address
//   wdata0     in   DATA_W  port 0 write data
//   gnt0       out  1       port 0 request accepted (1-cycle pulse)
//   rvalid0    out  1       port 0 access complete; rdata valid if read (1-cycle pulse)
//   req1/we1/addr1/wdata1   in   as port 0, for port 1
//   gnt1, rvalid1           out  as port 0, for port 1
//   rdata      out  DATA_W  read data of last completed access (shared by both ports)
//   busy       out  1       1 while state != IDLE
//   mem_addr   out  ADDR_W  data memory address
//   mem_we     out  1       data memory write enable
//   mem_wdata  out  DATA_W  data memory write data
//   mem_rdata  in   DATA_W  data memory read data (combinational from mem_addr)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; gnt*, rvalid*, busy, mem_we = 0;
//     rdata, mem_addr, mem_wdata = 0; last_winner = 1 (port 0 wins first tie).
//     Reset mid-access aborts it: mem_we drops immediately, no rvalid issued.
//   IDLE: requests sampled only here. On posedge with any req:
//     - winner = only requester, or ~last_winner if both requesting.
//     - latch winner's we/addr/wdata into sel_we/sel_addr/sel_wdata; record
//       sel_port; last_winner <= winner; gnt<winner> <= 1; state -> ACCESS.
//     No req: stay IDLE, all pulses 0.
//   ACCESS (1 cycle): mem_addr=sel_addr, mem_wdata=sel_wdata,
//     mem_we = sel_we (mem_we is 0 in every other state). gnt<sel_port>=1 this
//     cycle only. Posedge: if !sel_we, rdata <= mem_rdata; rvalid<sel_port> <= 1;
//     state -> RESP.
//   RESP (1 cycle): rvalid<sel_port>=1; rdata holds; state -> IDLE.
//   Latency: req seen at edge N -> gnt high cycle N+1 -> rvalid high cycle N+2;
//     read data on rdata from cycle N+2 until next read completes.
//   Throughput: one access per 3 cycles; requester holding req through RESP is
//     re-sampled in IDLE as a new request (back-to-back allowed, fairness kept).
//   Write: rdata unchanged; rvalid is a write acknowledge.
//   mem_addr/mem_wdata outside ACCESS hold last latched values (don't care).
//   gnt0&gnt1 and rvalid0&rvalid1 never both 1. Inputs changing while not in
//     IDLE are ignored (latched copies used).
// TESTING
//   1. Reset: rst_n=0 mid-ACCESS with we0=1 -> mem_we=0 same cycle, no rvalid0,
//      state IDLE, rdata=0 after release.
//   2. Single write then read, port 0: write addr 0x0005 data 0xDEADBEEF, then read
//      0x0005 -> gnt0 at N+1, rvalid0 at N+2, rdata=0xDEADBEEF; mem_we high exactly 1 cycle.
//   3. Simultaneous first request: req0=req1=1 after reset -> port 0 granted first,
//      port 1 granted in the next IDLE; 4 held-both rounds -> grants 0,1,0,1.
//   4. Single requester starvation-free: req1 held continuously, req0 idle -> gnt1
//      every 3 cycles; raise req0 -> next grant goes to port 0.
//   5. Address/data isolation: port 1 writes 0x7FFF=0x12345678 while port 0 reads
//      0x7FFF queued behind -> port 0 rdata=0x12345678; input change during ACCESS
//      (addr1 -> 0x0000) does not alter mem_addr.
//   6. Write ack: port 1 write -> rvalid1 pulses, rdata keeps previous read value.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between CPU (port 0) and DMA (port 1).
// Latency: request sampled at edge N -> gnt during cycle N+1 -> rvalid/rdata during cycle N+2.
// Backpressure: requesters hold req until their gnt; one access in flight, one access per 3 cycles.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req0/we0/addr0/wdata0          port 0 request (CPU load/store)
//   gnt0, rvalid0                  port 0 accept pulse, completion pulse
//   req1/we1/addr1/wdata1          port 1 request (loader/debug DMA)
//   gnt1, rvalid1                  port 1 accept pulse, completion pulse
//   rdata                          read data of the last completed read (shared)
//   busy                           high while an access is in progress
//   mem_addr/mem_we/mem_wdata      data memory request side
//   mem_rdata                      data memory combinational read data

module dmem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                sel_we_q, sel_we_d;
  logic [ADDR_W-1:0]   sel_addr_q, sel_addr_d;
  logic [DATA_W-1:0]   sel_wdata_q, sel_wdata_d;
  logic                sel_port_q, sel_port_d;
  logic                last_winner_q, last_winner_d;
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                winner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sel_we_q      <= 1'b0;
      sel_addr_q    <= '0;
      sel_wdata_q   <= '0;
      sel_port_q    <= 1'b0;
      // Starting at 1 makes port 0 win the first simultaneous request.
      last_winner_q <= 1'b1;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      sel_we_q      <= sel_we_d;
      sel_addr_q    <= sel_addr_d;
      sel_wdata_q   <= sel_wdata_d;
      sel_port_q    <= sel_port_d;
      last_winner_q <= last_winner_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
      rdata_q       <= rdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_we_d      = sel_we_q;
    sel_addr_d    = sel_addr_q;
    sel_wdata_d   = sel_wdata_q;
    sel_port_d    = sel_port_q;
    last_winner_d = last_winner_q;
    gnt0_d        = 1'b0;
    gnt1_d        = 1'b0;
    rvalid0_d     = 1'b0;
    rvalid1_d     = 1'b0;
    rdata_d       = rdata_q;
    winner        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // Lone requester wins outright; on a tie the port that lost last time wins.
          winner        = (req0 && req1) ? ~last_winner_q : req1;
          sel_port_d    = winner;
          last_winner_d = winner;
          sel_we_d      = winner ? we1    : we0;
          sel_addr_d    = winner ? addr1  : addr0;
          sel_wdata_d   = winner ? wdata1 : wdata0;
          gnt0_d        = ~winner;
          gnt1_d        = winner;
          state_d       = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!sel_we_q) begin
          rdata_d = mem_rdata;
        end
        rvalid0_d = ~sel_port_q;
        rvalid1_d = sel_port_q;
        state_d   = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign mem_addr  = sel_addr_q;
  assign mem_wdata = sel_wdata_q;
  // Decoded from state so an asynchronous reset kills a write in the same cycle.
  assign mem_we    = (state_q == S_ACCESS) && sel_we_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Memory reads combinationally from mem_addr and writes on the rising edge.

module tb_dmem_arbiter;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1, busy, mem_we;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
    chk("rvalid_excl", 32'(rvalid0 & rvalid1), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // ---- reset values ----
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);

    // ---- 1: reset in the middle of a port 0 write ----
    req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0005; wdata0 = 32'h1111_2222;
    step();
    chk("t1_gnt0", 32'(gnt0), 32'd1);
    chk("t1_mem_we_on", 32'(mem_we), 32'd1);
    req0 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("t1_mem_we_abort", 32'(mem_we), 32'd0);
    chk("t1_busy_abort", 32'(busy), 32'd0);
    chk("t1_gnt0_abort", 32'(gnt0), 32'd0);
    step();
    chk("t1_no_rvalid0", 32'(rvalid0), 32'd0);
    rst_n = 1'b1;
    step();
    chk("t1_rdata", rdata, 32'd0);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // ---- 2: port 0 write 0x0005 then read it back ----
    req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0005; wdata0 = 32'hDEAD_BEEF;
    step();
    chk("t2w_gnt0", 32'(gnt0), 32'd1);
    chk("t2w_mem_we", 32'(mem_we), 32'd1);
    chk("t2w_mem_addr", 32'(mem_addr), 32'h0005);
    chk("t2w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    req0 = 1'b0;
    step();
    chk("t2w_rvalid0", 32'(rvalid0), 32'd1);
    chk("t2w_gnt0_off", 32'(gnt0), 32'd0);
    chk("t2w_mem_we_off", 32'(mem_we), 32'd0);
    chk("t2w_rdata_kept", rdata, 32'd0);
    chk("t2w_mem_content", mem[15'h0005], 32'hDEAD_BEEF);
    step();
    chk("t2w_rvalid0_off", 32'(rvalid0), 32'd0);
    chk("t2w_busy_off", 32'(busy), 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0005; wdata0 = 32'h0;
    step();
    chk("t2r_gnt0", 32'(gnt0), 32'd1);
    chk("t2r_mem_we", 32'(mem_we), 32'd0);
    req0 = 1'b0;
    step();
    chk("t2r_rvalid0", 32'(rvalid0), 32'd1);
    chk("t2r_rdata", rdata, 32'hDEAD_BEEF);
    step();

    // ---- 3: simultaneous requests after reset alternate 0,1,0,1 ----
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0001;
    req1 = 1'b1; we1 = 1'b0; addr1 = 15'h0002;
    for (int r = 0; r < 4; r++) begin
      step();
      chk($sformatf("t3_gnt0_r%0d", r), 32'(gnt0), (r % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t3_gnt1_r%0d", r), 32'(gnt1), (r % 2 == 1) ? 32'd1 : 32'd0);
      step();
      chk($sformatf("t3_rvalid0_r%0d", r), 32'(rvalid0), (r % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t3_rvalid1_r%0d", r), 32'(rvalid1), (r % 2 == 1) ? 32'd1 : 32'd0);
      step();
    end

    // ---- 4: lone port 1 served every 3 cycles, then port 0 gets the next tie ----
    req0 = 1'b0;
    for (int r = 0; r < 2; r++) begin
      step();
      chk($sformatf("t4_gnt1_r%0d", r), 32'(gnt1), 32'd1);
      step();
      chk($sformatf("t4_gnt1_low_r%0d", r), 32'(gnt1), 32'd0);
      chk($sformatf("t4_rvalid1_r%0d", r), 32'(rvalid1), 32'd1);
      step();
      chk($sformatf("t4_idle_r%0d", r), 32'(busy), 32'd0);
    end
    req0 = 1'b1;
    step();
    chk("t4_gnt0_after_raise", 32'(gnt0), 32'd1);
    chk("t4_gnt1_after_raise", 32'(gnt1), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();

    // ---- 5: port 1 write to 0x7FFF, port 0 read of 0x7FFF queued behind ----
    req1 = 1'b1; we1 = 1'b1; addr1 = 15'h7FFF; wdata1 = 32'h1234_5678;
    req0 = 1'b1; we0 = 1'b0; addr0 = 15'h7FFF;
    step();
    chk("t5_gnt1", 32'(gnt1), 32'd1);
    addr1 = 15'h0000;
    req1  = 1'b0;
    #1;
    chk("t5_mem_addr_held", 32'(mem_addr), 32'h7FFF);
    step();
    chk("t5_rvalid1", 32'(rvalid1), 32'd1);
    step();
    step();
    chk("t5_gnt0", 32'(gnt0), 32'd1);
    chk("t5_mem_addr_rd", 32'(mem_addr), 32'h7FFF);
    req0 = 1'b0;
    step();
    chk("t5_rvalid0", 32'(rvalid0), 32'd1);
    chk("t5_rdata", rdata, 32'h1234_5678);
    step();

    // ---- 6: port 1 write acknowledge leaves rdata alone ----
    req1 = 1'b1; we1 = 1'b1; addr1 = 15'h0010; wdata1 = 32'hCAFE_F00D;
    step();
    chk("t6_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    step();
    chk("t6_rvalid1", 32'(rvalid1), 32'd1);
    chk("t6_rdata_kept", rdata, 32'h1234_5678);
    chk("t6_mem_content", mem[15'h0010], 32'hCAFE_F00D);
    step();
    chk("t6_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
